// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage core: stalls, flushes, EX forwarding
// selects and the HALT drain/freeze sequence.
module hazard_ctrl #(
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      inst_in_f_if,
  input  logic             branch_taken_f_ex,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_rs_sel_2_ex,
  output logic [1:0]       fwd_rt_sel_2_ex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t     r_state, w_nstate;
  logic [1:0] r_cnt;
  logic       r_ex_v, r_ex_ld, r_mem_v;
  logic [4:0] r_ex_dst, r_mem_dst;
  logic [1:0] r_rs_sel, r_rt_sel;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd, w_dst;
  logic       w_use_rs, w_use_rt, w_is_ld, w_is_halt, w_dst_v;
  logic       w_rs_ex, w_rt_ex, w_rs_mem, w_rt_mem, w_hz;
  logic       w_stall_inc;
  logic [1:0] w_rs_sel, w_rt_sel;
  logic       w_unused;

  assign w_op     = inst_in_f_if[31:26];
  assign w_rs     = inst_in_f_if[25:21];
  assign w_rt     = inst_in_f_if[20:16];
  assign w_rd     = inst_in_f_if[15:11];
  assign w_unused = ^inst_in_f_if[10:0];

  always_comb begin
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_dst     = 5'd0;
    w_is_ld   = 1'b0;
    w_is_halt = 1'b0;
    if (w_op <= 6'h0B) begin
      w_use_rs = 1'b1;
      if (!w_op[0]) begin
        w_use_rt = 1'b1;
        w_dst    = w_rd;
      end else begin
        w_dst    = w_rt;
      end
    end else begin
      case (w_op)
        6'h0C: begin w_use_rs = 1'b1; w_dst = w_rt; w_is_ld = 1'b1; end
        6'h0D, 6'h0F: begin w_use_rs = 1'b1; w_use_rt = 1'b1; end
        6'h0E, 6'h10: w_use_rs = 1'b1;
        6'h11: w_is_halt = 1'b1;
        default: ;
      endcase
    end
  end

  // r0 is hardwired, so it neither produces nor consumes a dependency
  assign w_dst_v  = (w_dst != 5'd0);
  assign w_rs_ex  = w_use_rs && (w_rs != 5'd0) && r_ex_v  && (r_ex_dst  == w_rs);
  assign w_rt_ex  = w_use_rt && (w_rt != 5'd0) && r_ex_v  && (r_ex_dst  == w_rt);
  assign w_rs_mem = w_use_rs && (w_rs != 5'd0) && r_mem_v && (r_mem_dst == w_rs);
  assign w_rt_mem = w_use_rt && (w_rt != 5'd0) && r_mem_v && (r_mem_dst == w_rt);

  assign w_hz = (r_ex_ld && (w_rs_ex || w_rt_ex)) ||
                ((FWD_EN == 0) && (w_rs_ex || w_rt_ex || w_rs_mem || w_rt_mem));

  assign w_rs_sel = w_rs_ex ? 2'b01 : (w_rs_mem ? 2'b10 : 2'b00);
  assign w_rt_sel = w_rt_ex ? 2'b01 : (w_rt_mem ? 2'b10 : 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate     = r_state;
    pc_hold      = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    w_stall_inc  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (branch_taken_f_ex) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (w_hz) begin
          pc_hold      = 1'b1;
          if_id_hold   = 1'b1;
          id_ex_bubble = 1'b1;
          w_stall_inc  = 1'b1;
        end else if (w_is_halt) begin
          pc_hold    = 1'b1;
          if_id_hold = 1'b1;
          w_nstate   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
        // HALT sits in WB as the count reaches zero
        if (r_cnt == 2'd1) w_nstate = S_HALTED;
      end
      S_HALTED: begin
        pc_hold      = 1'b1;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end
      default: w_nstate = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    r_cnt <= 2'd0;
    else if (r_state == S_RUN && w_nstate == S_DRAIN) r_cnt <= 2'd2;
    else if (r_state == S_DRAIN)                   r_cnt <= r_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_v    <= 1'b0;
      r_ex_ld   <= 1'b0;
      r_ex_dst  <= 5'd0;
      r_mem_v   <= 1'b0;
      r_mem_dst <= 5'd0;
      r_rs_sel  <= 2'b00;
      r_rt_sel  <= 2'b00;
    end else if (r_state != S_HALTED) begin
      r_mem_v   <= r_ex_v;
      r_mem_dst <= r_ex_dst;
      if (id_ex_bubble) begin
        r_ex_v   <= 1'b0;
        r_ex_ld  <= 1'b0;
        r_ex_dst <= 5'd0;
        r_rs_sel <= 2'b00;
        r_rt_sel <= 2'b00;
      end else begin
        r_ex_v   <= w_dst_v;
        r_ex_ld  <= w_is_ld && w_dst_v;
        r_ex_dst <= w_dst;
        r_rs_sel <= w_rs_sel;
        r_rt_sel <= w_rt_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  assign fwd_rs_sel_2_ex = r_rs_sel;
  assign fwd_rt_sel_2_ex = r_rt_sel;
  assign stall_cnt       = r_stall_cnt;
  assign halted          = (r_state == S_HALTED);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Random-stimulus scoreboard bench for hazard_ctrl: one forwarding instance and
// one stall-only instance with a narrow counter, both fed the same ID stream.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] inst = '0;
  logic        br = 1'b0;

  logic       ph0, ih0, fl0, bb0, hl0, ph1, ih1, fl1, bb1, hl1;
  logic [1:0] rs0, rt0, rs1, rt1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  always #5 clk = ~clk;

  hazard_ctrl #(.FWD_EN(1), .CNT_W(16)) u_fwd (
    .clk(clk), .reset(reset), .inst_in_f_if(inst), .branch_taken_f_ex(br),
    .pc_hold(ph0), .if_id_hold(ih0), .if_id_flush(fl0), .id_ex_bubble(bb0),
    .fwd_rs_sel_2_ex(rs0), .fwd_rt_sel_2_ex(rt0), .halted(hl0), .stall_cnt(sc0));

  hazard_ctrl #(.FWD_EN(0), .CNT_W(4)) u_nofwd (
    .clk(clk), .reset(reset), .inst_in_f_if(inst), .branch_taken_f_ex(br),
    .pc_hold(ph1), .if_id_hold(ih1), .if_id_flush(fl1), .id_ex_bubble(bb1),
    .fwd_rs_sel_2_ex(rs1), .fwd_rt_sel_2_ex(rt1), .halted(hl1), .stall_cnt(sc1));

  // In-flight view: destination (0 = none) of the instruction in EX and MEM,
  // plus how many cycles have passed since a HALT left ID (-1 = running).
  typedef struct {
    int ex_dst; bit ex_ld; int mem_dst;
    int rs_sel; int rt_sel; int cnt; int halt_age;
  } mdl_t;

  typedef struct { bit urs; bit urt; int dst; bit ld; bit hlt; } dec_t;

  typedef struct { logic [24:0] e0; logic [24:0] e1; int cyc; } exp_t;

  exp_t q[$];
  mdl_t m0, m1;
  int total = 0;
  int bad = 0;

  function automatic dec_t decode(input logic [31:0] in);
    dec_t d;
    int op;
    op = int'(in[31:26]);
    d = '{0, 0, 0, 0, 0};
    if (op <= 11) begin
      d.urs = 1;
      if (op % 2 == 0) begin d.urt = 1; d.dst = int'(in[15:11]); end
      else d.dst = int'(in[20:16]);
    end else if (op == 12) begin d.urs = 1; d.dst = int'(in[20:16]); d.ld = 1; end
    else if (op == 13 || op == 15) begin d.urs = 1; d.urt = 1; end
    else if (op == 14 || op == 16) d.urs = 1;
    else if (op == 17) d.hlt = 1;
    return d;
  endfunction

  function automatic mdl_t mreset();
    mdl_t m;
    m = '{0, 0, 0, 0, 0, 0, -1};
    return m;
  endfunction

  task automatic model_step(input bit fwd, input int cmax, input logic [31:0] in,
                            input bit b, input bit rst, inout mdl_t m,
                            output logic [24:0] e);
    dec_t d;
    int rs, rt, nrs, nrt;
    bit ex_rs, ex_rt, mem_rs, mem_rt, hz, run, ph, ih, fl, bub, hlt;
    if (rst) m = mreset();
    d  = decode(in);
    rs = int'(in[25:21]);
    rt = int'(in[20:16]);
    ex_rs  = d.urs && rs != 0 && rs == m.ex_dst;
    ex_rt  = d.urt && rt != 0 && rt == m.ex_dst;
    mem_rs = d.urs && rs != 0 && rs == m.mem_dst;
    mem_rt = d.urt && rt != 0 && rt == m.mem_dst;
    hz  = (m.ex_ld && (ex_rs || ex_rt)) || (!fwd && (ex_rs || ex_rt || mem_rs || mem_rt));
    run = m.halt_age < 0;
    hlt = m.halt_age >= 3;
    ph = 0; ih = 0; fl = 0; bub = 0;
    if (!run) begin ph = 1; ih = 1; bub = 1; end
    else if (b) begin fl = 1; bub = 1; end
    else if (hz) begin ph = 1; ih = 1; bub = 1; end
    else if (d.hlt) begin ph = 1; ih = 1; end
    e = {ph, ih, fl, bub, 2'(m.rs_sel), 2'(m.rt_sel), hlt, 16'(m.cnt)};
    if (!rst && !hlt) begin
      if (run && hz && !b && m.cnt < cmax) m.cnt++;
      nrs = ex_rs ? 1 : (mem_rs ? 2 : 0);
      nrt = ex_rt ? 1 : (mem_rt ? 2 : 0);
      m.mem_dst = m.ex_dst;
      if (bub) begin
        m.ex_dst = 0; m.ex_ld = 0; m.rs_sel = 0; m.rt_sel = 0;
      end else begin
        m.ex_dst = d.dst; m.ex_ld = d.ld; m.rs_sel = nrs; m.rt_sel = nrt;
      end
      if (run && d.hlt && !b) m.halt_age = 1;
      else if (m.halt_age > 0) m.halt_age++;
    end
  endtask

  // Monitor: every cycle the DUTs present a full output set, checked mid-cycle.
  initial begin
    exp_t x;
    logic [24:0] a0, a1;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        x  = q.pop_front();
        a0 = {ph0, ih0, fl0, bb0, rs0, rt0, hl0, sc0};
        a1 = {ph1, ih1, fl1, bb1, rs1, rt1, hl1, 12'd0, sc1};
        total++;
        if (a0 !== x.e0) begin
          bad++;
          $display("FAIL fwd_outs cyc=%0d got=%h want=%h", x.cyc, a0, x.e0);
        end
        total++;
        if (a1 !== x.e1) begin
          bad++;
          $display("FAIL nofwd_outs cyc=%0d got=%h want=%h", x.cyc, a1, x.e1);
        end
      end
    end
  end

  // Driver: random ID instructions over r0..r3 to force frequent hazards.
  initial begin
    exp_t x;
    bit do_rst;
    int hc, r;
    logic [5:0] op;
    m0 = mreset();
    m1 = mreset();
    hc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      do_rst = (c < 2) || (hc >= 4) || (m0.halt_age == 1 && $urandom_range(0, 1) == 0) ||
               ($urandom_range(0, 299) == 0);
      reset = !do_rst;
      r = $urandom_range(0, 49);
      if (r == 0)      op = 6'h11;
      else if (r == 1) op = 6'($urandom_range(18, 63));
      else             op = 6'($urandom_range(0, 16));
      inst = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 11'($urandom)};
      br = ($urandom_range(0, 5) == 0);
      model_step(1'b1, 65535, inst, br, do_rst, m0, x.e0);
      model_step(1'b0, 15,    inst, br, do_rst, m1, x.e1);
      x.cyc = c;
      q.push_back(x);
      if (m0.halt_age >= 3) hc++;
      else hc = 0;
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage core (IF, ID, EX, MEM, WB).
- Watches the instruction currently in ID (the IF/ID register output) and keeps its own shadow of the destination registers in flight in EX and MEM.
- From that it produces PC/IF-ID hold, IF-ID flush, ID-EX bubble and forwarding selects for EX.
- It also sequences HALT: drains the pipe, then freezes the core.

Parameters:
- FWD_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = stall until producer leaves MEM.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- inst_in_f_if  input  32  instruction held in IF/ID (opcode [31:26], rs [25:21], rt [20:16], rd [15:11]).
- branch_taken_f_ex  input  1  branch/JR resolved taken in EX this cycle.
- pc_hold  output  1  PC keeps its value.
- if_id_hold  output  1  IF/ID register keeps its value.
- if_id_flush  output  1  IF/ID loads a NOP (all zero).
- id_ex_bubble  output  1  ID/EX loads all zero instead of the decoded instruction.
- fwd_rs_sel_2_ex  output  2  rs operand select in EX: 00 ID/EX value, 01 EX/MEM result, 10 MEM/WB result.
- fwd_rt_sel_2_ex  output  2  same encoding, for rt.
- halted  output  1  core frozen after HALT retired.
- stall_cnt  output  CNT_W  saturating count of load-use and dependency stall cycles.

Behaviour:

Decode of the ID instruction:
- Even opcodes 0x00-0x0A (R-type): sources rs and rt; dest rd.
- Odd opcodes 0x01-0x0B (immediate): source rs; dest rt.
- 0x0C LDW: source rs; dest rt; is_load = 1.
- 0x0D STW: sources rs and rt; no dest.
- 0x0E BZ and 0x10 JR: source rs; no dest.
- 0x0F BEQ: sources rs and rt; no dest.
- 0x11 HALT: no sources, no dest. Other opcodes: treated as NOP.
- Dest register 0 never creates a dependency. Source register 0 never matches.

Tracker registers (reset all 0): ex_v, ex_dst[4:0], ex_ld, mem_v, mem_dst[4:0].
- Each non-halted cycle: the mem fields take the ex fields.
- The ex fields take the decoded ID instruction, unless id_ex_bubble is high; in that case ex_v = 0.

Hazards (combinational; all outputs low when no hazard):
- Load-use: ex_v & ex_ld & ex_dst matches a used source gives stall = 1.
- FWD_EN = 0: any match against a valid ex_dst or mem_dst gives stall = 1.
- stall drives pc_hold = if_id_hold = id_ex_bubble = 1.
- Registered forward selects: updated whenever ID/EX loads.
  - Match on ex_dst gives 01; otherwise a match on mem_dst gives 10; otherwise 00. EX has priority over MEM.
  - A bubble loads 00.
- WB-to-ID write-through is the register file's job and is not tracked here.

Branch:
- branch_taken_f_ex drives if_id_flush = 1 and id_ex_bubble = 1 in the same cycle.
- Flush beats stall: pc_hold = 0 and if_id_hold = 0, so the PC takes the target.
- A stall does not increment stall_cnt in a flush cycle.

HALT state machine: RUN -> DRAIN -> HALTED.
- RUN: on HALT in ID with no flush, pc_hold = if_id_hold = 1, load the HALT into EX, go to DRAIN with cnt = 2.
- HALT in ID together with a flush: HALT is discarded and the FSM stays in RUN.
- DRAIN:
  - pc_hold = if_id_hold = id_ex_bubble = 1.
  - cnt decrements each cycle.
  - At cnt == 0 (HALT in WB), go to HALTED.
- HALTED: halted = 1; pc_hold, if_id_hold and id_ex_bubble held at 1; tracker frozen. Exit only by reset.

Reset:
- Reset asserted at any time, including mid-stall or DRAIN, clears the FSM to RUN, the tracker, the fwd selects, stall_cnt and halted to 0.
- The first cycle after reset is RUN with no hazards.
- stall_cnt saturates at all-ones.

Test Plan:
- LDW r3 in EX, ID = add rd=r5 rs=r3 rt=r4 -> one cycle with pc_hold/if_id_hold/id_ex_bubble = 1 and stall_cnt = 1; next edge fwd_rs_sel_2_ex = 10.
- add r7 in EX, ID = addi rs=r7 -> no stall; fwd_rs_sel_2_ex = 01. Same with r7 in MEM only -> 10. r7 in both EX and MEM -> 01.
- Producer dest r0, consumer rs=r0 -> no stall; sel = 00.
- FWD_EN=0, add r2 then sub rs=r2 -> two stall cycles; stall_cnt = 2.
- branch_taken_f_ex together with a load-use stall -> if_id_flush = 1, id_ex_bubble = 1, pc_hold = 0; stall_cnt unchanged.
- HALT in ID -> halted rises 3 cycles later and stays 1. Reset (reset = 0) during DRAIN -> halted = 0, FSM in RUN.
